// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   state_t           : loader FSM states
//   DEFAULT_MEM_WORDS : default instruction-memory depth in 32-bit words
//   BYTES_PER_WORD    : bytes assembled into each instruction word
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int DEFAULT_MEM_WORDS = 64;
  localparam int BYTES_PER_WORD    = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Assembles a little-endian byte stream into 32-bit words.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the byte counter at lane 0
//   load       : accept byte_in into the lane selected by the byte counter
//   byte_in    : incoming byte
//   word       : assembled word, lane k on bits [8k+7:8k]
//   full       : the byte accepted this cycle completes the word
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] byte_cnt_reg;

  // Combinational so the FSM can leave COLLECT on the same edge that
  // captures the last byte.
  assign full = load && (byte_cnt_reg == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_reg <= '0;
    end else if (clear) begin
      byte_cnt_reg <= '0;
    end else if (load) begin
      byte_cnt_reg <= byte_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (load && (byte_cnt_reg == CW'(gi))) begin
          lane_reg <= byte_in;
        end
      end

      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/prog_loader.sv
// Loads a program from a byte stream into instruction memory while holding
// the processor core in reset.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start, len_words     : load request and its length in words
//   byte_valid/byte_data : byte source, byte_ready is the handshake back
//   imem_we/addr/wdata   : instruction-memory write port
//   core_reset           : held high until a load completes, and during loads
//   busy                 : a load is in progress
//   done                 : one-cycle pulse when a load completes
//   err                  : one-cycle pulse when a start is rejected
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len_words,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] MAX_LEN = (AW+1)'(MEM_WORDS);

  state_t        state_reg;
  logic [AW:0]   len_reg;
  logic [AW-1:0] word_cnt_reg;
  logic          loaded_reg;
  logic          byte_ready_reg;
  logic          we_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;

  logic          len_ok;
  logic          accept_start;
  logic          byte_accept;
  logic          asm_clear;
  logic          word_full;
  logic          last_word;
  logic [31:0]   word;

  assign len_ok       = (len_words != '0) && (len_words <= MAX_LEN);
  assign accept_start = (state_reg == IDLE) && start && len_ok;
  // byte_ready_reg is only ever set while in COLLECT.
  assign byte_accept  = byte_valid && byte_ready_reg;
  assign asm_clear    = accept_start || (state_reg == WRITE);
  assign last_word    = ({1'b0, word_cnt_reg} == (len_reg - 1'b1));

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .clear   (asm_clear),
    .load    (byte_accept),
    .byte_in (byte_data),
    .word    (word),
    .full    (word_full)
  );

  // Every output is set on the edge that enters the state it belongs to,
  // so they stay registered and aligned with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      word_cnt_reg   <= '0;
      loaded_reg     <= 1'b0;
      byte_ready_reg <= 1'b0;
      we_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_reg        <= len_words;
              word_cnt_reg   <= '0;
              byte_ready_reg <= 1'b1;
              busy_reg       <= 1'b1;
              state_reg      <= COLLECT;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (word_full) begin
            byte_ready_reg <= 1'b0;
            we_reg         <= 1'b1;
            state_reg      <= WRITE;
          end
        end
        WRITE: begin
          if (last_word) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            word_cnt_reg   <= word_cnt_reg + 1'b1;
            byte_ready_reg <= 1'b1;
            state_reg      <= COLLECT;
          end
        end
        FINISH: begin
          loaded_reg <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = word_cnt_reg;
  assign imem_wdata = word;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign core_reset = !loaded_reg || busy_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver pushes expected writes,
// done/err cycles and load starts; a negedge monitor pops and compares.
module tb_prog_loader;

  localparam int MEM_WORDS = 64;
  localparam int AW        = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  prog_loader #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  err_q[$];
  int  start_q[$];

  logic [7:0] stim_bytes [0:255];
  int         stim_gap   [0:255];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_now(string name);
    checks++;
    $display("FAIL %s: got none, expected an event (cycle %0d)", name, cyc);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit loaded_m  = 1'b0;
  bit in_load_m = 1'b0;
  bit rst_prev  = 1'b0;

  always @(negedge clk) begin
    if (rst_prev) begin
      loaded_m  = 1'b0;
      in_load_m = 1'b0;
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_core_reset", core_reset, 1);
    end else if (!reset) begin
      if (start_q.size() > 0 && cyc >= start_q[0]) begin
        void'(start_q.pop_front());
        in_load_m = 1'b1;
      end
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("imem_addr", imem_addr, e.addr);
          chk("imem_wdata", imem_wdata, e.data);
          $display("write addr=%0d data=%h cycle=%0d", imem_addr, imem_wdata, cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done_cycle", cyc, 32'hFFFF_FFFF);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err_cycle", cyc, 32'hFFFF_FFFF);
        else chk("err_cycle", cyc, err_q.pop_front());
      end
      chk("core_reset", core_reset, (!loaded_m || in_load_m) ? 1 : 0);
      if (done) begin
        loaded_m  = 1'b1;
        in_load_m = 1'b0;
      end
    end
    rst_prev = reset;
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic bad_start(input int len);
    len_words = (AW+1)'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    err_q.push_back(cyc);
    $display("bad start len=%0d cycle=%0d", len, cyc);
    @(posedge clk); #1;
  endtask

  // abort_after: reset once this many bytes have transferred (-1 = never)
  // pulse_at: byte index during which a stray start is held (-1 = never)
  task automatic run_load(input int len, input int abort_after, input int pulse_at);
    int acc;
    int gaps;
    int nbytes;
    bit ok;
    gaps   = 0;
    nbytes = len * 4;
    len_words = (AW+1)'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    start_q.push_back(acc);
    for (int i = 0; i < nbytes; i++) begin
      if (i == abort_after) break;
      if ((i % 4) != 0 && stim_gap[i] > 0) begin
        byte_valid = 1'b0;
        repeat (stim_gap[i]) @(posedge clk);
        #1;
        gaps += stim_gap[i];
      end
      byte_valid = 1'b1;
      byte_data  = stim_bytes[i];
      if (i == pulse_at) begin
        start = 1'b1;
        len_words = (AW+1)'($urandom_range(1, 4));
      end
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (byte_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("byte_ready_timeout");
      @(posedge clk); #1;
      start = 1'b0;
      if ((i % 4) == 3)
        wr_q.push_back('{i / 4, {stim_bytes[i], stim_bytes[i-1], stim_bytes[i-2], stim_bytes[i-3]}});
    end
    if (abort_after >= 0) begin
      // reset with a byte still offered: reset must win
      byte_valid = 1'b1;
      byte_data  = stim_bytes[abort_after];
      $display("load len=%0d aborted after %0d bytes cycle=%0d", len, abort_after, cyc);
      do_reset();
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      byte_valid = 1'b0;
      done_q.push_back(acc + 5 * len + gaps);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (done) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("done_timeout");
      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("load len=%0d gaps=%0d accepted at cycle %0d", len, gaps, acc);
    end
  endtask

  task automatic fill_random(input int nbytes, input bit with_gaps);
    for (int i = 0; i < nbytes; i++) begin
      stim_bytes[i] = 8'($urandom);
      stim_gap[i]   = (with_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    len_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    for (int i = 0; i < 256; i++) begin
      stim_bytes[i] = '0;
      stim_gap[i]   = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // rejected starts before anything is loaded
    bad_start(0);
    bad_start(65);

    // two-word program, valid held high
    begin
      logic [7:0] prog [0:7];
      prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) begin
        stim_bytes[i] = prog[i];
        stim_gap[i]   = 0;
      end
    end
    run_load(2, -1, -1);

    // single word with a 3-cycle gap before byte 1
    fill_random(4, 1'b0);
    stim_gap[1] = 3;
    run_load(1, -1, -1);

    // abort a 3-word load after 6 bytes, then restart
    fill_random(12, 1'b0);
    run_load(3, 6, -1);
    fill_random(12, 1'b0);
    run_load(3, -1, -1);

    // stray start during COLLECT
    fill_random(16, 1'b1);
    run_load(4, -1, 5);

    // full memory
    fill_random(256, 1'b0);
    run_load(64, -1, -1);

    // randomized loads with gaps, stray starts and rejected starts
    for (int n = 0; n < 6; n++) begin
      int len;
      len = int'($urandom_range(1, 8));
      fill_random(len * 4, 1'b1);
      run_load(len, -1, int'($urandom_range(1, len * 4 - 1)));
      if ($urandom_range(0, 1) == 1) bad_start(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(65, 127)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    chk("pending_err", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected one by 500000");
    $fatal(1);
  end

endmodule
